// File: rtl/lcd_sched.sv
// lcd_sched: arbitrates two byte-write requesters onto a 4-bit HD44780-style
// LCD bus. Each accepted byte goes out as two enable strobes (high nibble
// first). Clear/home commands (rs=0, byte 0x01..0x03) are followed by
// LONG_WAIT idle cycles before the bus is released.
// Optional feature: define LCD_SCHED_ROUND_ROBIN_EN for round-robin
// arbitration. When it is undefined, requester 0 has fixed priority.
module lcd_sched #(
  parameter int LONG_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] byte0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] byte1,
  output logic       ack1,
  output logic       busy,
  output logic       en,
  output logic       rs,
  output logic [3:0] data
);

  typedef enum logic [2:0] {
    IDLE,
    HI_ON,
    HI_OFF,
    LO_ON,
    LO_OFF,
    WAIT
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(LONG_WAIT - 1);

  state_t     state;
  logic [7:0] lat_byte;
  logic [3:0] wait_cnt;
  logic       any_req;
  logic       pick1;
  logic [7:0] sel_byte;
  logic       sel_rs;
  logic       long_cmd;
  logic       grant;

  assign any_req = req0 | req1;
  assign grant   = (state == IDLE) & init_done & any_req;

`ifdef LCD_SCHED_ROUND_ROBIN_EN
  logic last1;  // 1 = requester 1 was granted most recently

  // Round-robin: on a tie, grant the requester that did not win last time.
  assign pick1 = req1 & (~req0 | ~last1);

  // Pointer follows every grant; after reset it favours requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      last1 <= 1'b1;
    end else if (grant) begin
      last1 <= pick1;
    end
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is idle.
  assign pick1 = req1 & ~req0;
`endif

  assign sel_byte = pick1 ? byte1 : byte0;
  assign sel_rs   = pick1 ? rs1 : rs0;

  // Clear (0x01) and home (0x02/0x03) need extra settle time on the panel.
  assign long_cmd = ~rs & ((lat_byte == 8'h01) | (lat_byte == 8'h02) | (lat_byte == 8'h03));

  // Transaction sequencer with registered bus, ack and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lat_byte <= 8'h00;
      wait_cnt <= 4'd0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      en       <= 1'b0;
      rs       <= 1'b0;
      data     <= 4'h0;
    end else begin
      // NOTE: acks default low each cycle so the grant branch below yields a
      // single-cycle pulse; with non-blocking assignments the later write wins.
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= HI_ON;
            busy     <= 1'b1;
            lat_byte <= sel_byte;
            rs       <= sel_rs;
            data     <= sel_byte[7:4];
            en       <= 1'b1;
            ack0     <= ~pick1;
            ack1     <= pick1;
          end
        end
        HI_ON: begin
          en    <= 1'b0;
          state <= HI_OFF;
        end
        HI_OFF: begin
          en    <= 1'b1;
          data  <= lat_byte[3:0];
          state <= LO_ON;
        end
        LO_ON: begin
          en    <= 1'b0;
          state <= LO_OFF;
        end
        LO_OFF: begin
          if (long_cmd) begin
            wait_cnt <= 4'd0;
            state    <= WAIT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 4'd0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: begin
          en    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
